// File: rtl/tx_pulse_pkg.sv
// Shared state encoding, reset values and elaboration helpers for the
// write-domain pulse launcher.
package tx_pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HIGH    = 2'd1,
    ST_ACK_LOW = 2'd2,
    ST_GAP     = 2'd3
  } tx_state_e;

  localparam tx_state_e RST_STATE = ST_IDLE;
  localparam logic      RST_PULSE = 1'b0;
  localparam logic      RST_BUSY  = 1'b0;
  localparam logic      RST_ACK   = 1'b0;

  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchronizer with synchronous active-low reset; shared by
// the crossings in this codebase.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // first flop may go metastable; second flop gives a settled level
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/tx_stretch_pulse.sv
// Write-domain launcher: stretches single-cycle events into registered level
// pulses with guaranteed high time and low gap, optionally ack-held.
module tx_stretch_pulse
  import tx_pulse_pkg::*;
#(
  parameter int STRETCH = 4,
  parameter int GAP     = 2,
  parameter bit USE_ACK = 1'b0,
  parameter int CNT_W   = 16
) (
  input  logic             wr_clk,
  input  logic             wr_resetn,
  input  logic             wr_pulse,
  input  logic             rd_ack,
  output logic             stretched_pulse,
  output logic             busy,
  output logic [CNT_W-1:0] sent_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int               PH_W      = $clog2(max_int(STRETCH, GAP) + 1);
  localparam logic [PH_W-1:0]  HIGH_LAST = PH_W'(STRETCH - 1);
  localparam logic [PH_W-1:0]  GAP_LAST  = PH_W'(GAP - 1);
  localparam logic [PH_W-1:0]  PH_ONE    = PH_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  tx_state_e        state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             pulse_q;
  logic             busy_q;
  logic             ack_s;
  logic             high_done_s;

  sync_2ff #(
    .RST_VAL (RST_ACK)
  ) u_ack_sync (
    .clk_i    (wr_clk),
    .resetn_i (wr_resetn),
    .d_i      (rd_ack),
    .q_o      (ack_s)
  );

  // phase counter saturates in HIGH so a long ack wait cannot wrap it
  assign high_done_s = (phase_q == HIGH_LAST);

  // next-state, phase counter and event counters
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    sent_d  = sent_q;
    drop_d  = drop_q;
    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (wr_pulse) begin
          state_d = ST_HIGH;
          sent_d  = sent_q + CNT_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (high_done_s && (!USE_ACK || ack_s)) begin
          state_d = USE_ACK ? ST_ACK_LOW : ST_GAP;
          phase_d = '0;
        end else if (!high_done_s) begin
          phase_d = phase_q + PH_ONE;
        end else begin
          phase_d = phase_q;
        end
      end
      ST_ACK_LOW: begin
        phase_d = '0;
        if (!ack_s) begin
          state_d = ST_GAP;
        end else begin
          state_d = ST_ACK_LOW;
        end
      end
      ST_GAP: begin
        if (phase_q == GAP_LAST) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
    if (wr_pulse && (state_q != ST_IDLE) && (drop_q != CNT_MAX)) begin
      drop_d = drop_q + CNT_ONE;
    end else begin
      drop_d = drop_q;
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge wr_clk) begin
    if (!wr_resetn) begin
      state_q <= RST_STATE;
      phase_q <= '0;
      sent_q  <= '0;
      drop_q  <= '0;
      pulse_q <= RST_PULSE;
      busy_q  <= RST_BUSY;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      sent_q  <= sent_d;
      drop_q  <= drop_d;
      pulse_q <= (state_d == ST_HIGH);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign stretched_pulse = pulse_q;
  assign busy            = busy_q;
  assign sent_cnt        = sent_q;
  assign drop_cnt        = drop_q;

endmodule

// File: tb/tb_tx_stretch_pulse.sv
// Directed and co-simulation bench for tx_stretch_pulse across four
// configurations, with a launch-time scoreboard and a rd-domain receiver.
module tb_tx_stretch_pulse;

  logic wr_clk, rd_clk;
  logic rstn, a_rstn;
  logic a_pulse, b_pulse, c_pulse, r_pulse, b_ack;
  logic a_str, a_busy, b_str, b_busy, c_str, c_busy, r_str, r_busy;
  logic [15:0] a_sent, a_drop, b_sent, b_drop, r_sent, r_drop;
  logic [3:0]  c_sent, c_drop;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int a_q[$];
  int r_q[$];
  logic a_prev, r_prev;
  int r_rise = 0;
  logic rx_m, rx_s, rx_p;
  int rx_cnt = 0;

  tx_stretch_pulse #(.STRETCH(4), .GAP(2), .USE_ACK(1'b0), .CNT_W(16)) dut_a (
    .wr_clk(wr_clk), .wr_resetn(a_rstn), .wr_pulse(a_pulse), .rd_ack(1'b0),
    .stretched_pulse(a_str), .busy(a_busy), .sent_cnt(a_sent), .drop_cnt(a_drop));

  tx_stretch_pulse #(.STRETCH(4), .GAP(2), .USE_ACK(1'b1), .CNT_W(16)) dut_b (
    .wr_clk(wr_clk), .wr_resetn(rstn), .wr_pulse(b_pulse), .rd_ack(b_ack),
    .stretched_pulse(b_str), .busy(b_busy), .sent_cnt(b_sent), .drop_cnt(b_drop));

  tx_stretch_pulse #(.STRETCH(4), .GAP(2), .USE_ACK(1'b0), .CNT_W(4)) dut_c (
    .wr_clk(wr_clk), .wr_resetn(rstn), .wr_pulse(c_pulse), .rd_ack(1'b0),
    .stretched_pulse(c_str), .busy(c_busy), .sent_cnt(c_sent), .drop_cnt(c_drop));

  tx_stretch_pulse #(.STRETCH(8), .GAP(2), .USE_ACK(1'b0), .CNT_W(16)) dut_r (
    .wr_clk(wr_clk), .wr_resetn(rstn), .wr_pulse(r_pulse), .rd_ack(1'b0),
    .stretched_pulse(r_str), .busy(r_busy), .sent_cnt(r_sent), .drop_cnt(r_drop));

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  // rd_clk is wr_clk/3, offset so its edges never coincide with wr_clk edges
  initial begin
    rd_clk = 1'b0;
    #2;
    forever #15 rd_clk = ~rd_clk;
  end

  always @(posedge wr_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge wr_clk);
      #1;
    end
  endtask

  // scoreboard: each launch must rise in the cycle that was predicted at drive time
  always @(negedge wr_clk) begin
    if (a_str === 1'b1 && a_prev !== 1'b1) begin
      chk("a_rise_expected", {31'd0, a_q.size() != 0}, 32'd1);
      if (a_q.size() != 0) chk("a_rise_cyc", cyc, a_q.pop_front());
    end
    if (r_str === 1'b1 && r_prev !== 1'b1) begin
      chk("r_rise_expected", {31'd0, r_q.size() != 0}, 32'd1);
      if (r_q.size() != 0) chk("r_rise_cyc", cyc, r_q.pop_front());
      r_rise <= cyc;
    end
    if (r_str === 1'b0 && r_prev === 1'b1) chk("r_high_len", cyc - r_rise, 32'd8);
    a_prev <= a_str;
    r_prev <= r_str;
  end

  // rd-domain receiver: 2-FF sampler, counts trailing edges
  always @(posedge rd_clk) begin
    rx_m <= r_str;
    rx_s <= rx_m;
    rx_p <= rx_s;
    if (rx_p === 1'b1 && rx_s === 1'b0) rx_cnt <= rx_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int n;
    rstn = 1'b0; a_rstn = 1'b0;
    a_pulse = 1'b0; b_pulse = 1'b0; c_pulse = 1'b0; r_pulse = 1'b0; b_ack = 1'b0;

    // reset state
    goto(2);
    @(negedge wr_clk);
    chk("rst_a_pulse", a_str, 0);  chk("rst_a_busy", a_busy, 0);
    chk("rst_a_sent", a_sent, 0);  chk("rst_a_drop", a_drop, 0);
    chk("rst_b_pulse", b_str, 0);  chk("rst_c_busy", c_busy, 0);
    chk("rst_r_sent", r_sent, 0);
    goto(3);
    rstn = 1'b1; a_rstn = 1'b1;

    // single launch: high 11..14, busy 11..16
    for (int c = 9; c <= 18; c++) begin
      goto(c);
      a_pulse = (c == 10);
      if (c == 10) a_q.push_back(c + 1);
      @(negedge wr_clk);
      chk("a1_pulse", a_str, (c >= 11 && c <= 14));
      chk("a1_busy", a_busy, (c >= 11 && c <= 16));
    end
    chk("a1_sent", a_sent, 1);
    chk("a1_drop", a_drop, 0);

    // back-to-back requests 30..39: accepted at 30 and 37 only
    for (int c = 29; c <= 45; c++) begin
      goto(c);
      a_pulse = (c >= 30 && c <= 39);
      if (c == 30 || c == 37) a_q.push_back(c + 1);
      @(negedge wr_clk);
      chk("a2_pulse", a_str, ((c >= 31 && c <= 34) || (c >= 38 && c <= 41)));
      chk("a2_busy", a_busy, ((c >= 31 && c <= 36) || (c >= 38 && c <= 43)));
    end
    chk("a2_sent", a_sent, 3);
    chk("a2_drop", a_drop, 8);

    // reset mid-HIGH, with a same-cycle request that must be ignored
    goto(50); a_pulse = 1'b1; a_q.push_back(51);
    goto(51); a_pulse = 1'b0;
    goto(52); a_rstn = 1'b0; a_pulse = 1'b1;
    @(negedge wr_clk);
    chk("a3_sent_pre", a_sent, 4);
    goto(53); a_rstn = 1'b1; a_pulse = 1'b0;
    @(negedge wr_clk);
    chk("a3_pulse_rst", a_str, 0); chk("a3_busy_rst", a_busy, 0);
    chk("a3_sent_rst", a_sent, 0); chk("a3_drop_rst", a_drop, 0);
    goto(54); a_pulse = 1'b1; a_q.push_back(55);
    goto(55); a_pulse = 1'b0;
    @(negedge wr_clk);
    chk("a3_pulse_relaunch", a_str, 1); chk("a3_busy_relaunch", a_busy, 1);
    goto(56);
    @(negedge wr_clk);
    chk("a3_sent_relaunch", a_sent, 1);

    // ack mode: rd_ack 80..89, ack_s high at 82, pulse falls at 83
    for (int c = 69; c <= 98; c++) begin
      goto(c);
      b_pulse = (c == 70 || c == 85);
      b_ack = (c >= 80 && c <= 89);
      @(negedge wr_clk);
      chk("b_pulse", b_str, (c >= 71 && c <= 82));
      chk("b_busy", b_busy, (c >= 71 && c <= 94));
    end
    chk("b_sent", b_sent, 1);
    chk("b_drop", b_drop, 1);

    // 4-bit counters: continuous requests 100..123 give 4 accepts, 20 drops
    for (int c = 100; c <= 123; c++) begin
      goto(c);
      c_pulse = 1'b1;
      if (c == 117) begin
        @(negedge wr_clk);
        chk("c_drop_pre_sat", c_drop, 14);
      end
    end
    goto(124); c_pulse = 1'b0;
    goto(125);
    @(negedge wr_clk);
    chk("c_drop_sat", c_drop, 15);
    chk("c_sent_4", c_sent, 4);
    for (int i = 0; i < 13; i++) begin
      n = 130 + 8 * i;
      goto(n); c_pulse = 1'b1;
      goto(n + 1); c_pulse = 1'b0;
      if (i == 11) begin
        goto(n + 2);
        @(negedge wr_clk);
        chk("c_sent_wrap0", c_sent, 0);
      end
    end
    goto(228);
    @(negedge wr_clk);
    chk("c_sent_wrap1", c_sent, 1);
    chk("c_drop_hold", c_drop, 15);

    // receiver co-sim: 50 random-spaced events, none dropped or merged
    goto(240);
    for (int i = 0; i < 50; i++) begin
      gap = $urandom_range(24, 14);
      n = cyc + gap;
      goto(n); r_pulse = 1'b1; r_q.push_back(n + 1);
      goto(n + 1); r_pulse = 1'b0;
    end
    goto(cyc + 30);
    @(negedge wr_clk);
    chk("r_rx_cnt", rx_cnt, 50);
    chk("r_rx_vs_sent", rx_cnt, {16'd0, r_sent});
    chk("r_drop", r_drop, 0);
    chk("r_q_empty", r_q.size(), 0);
    chk("a_q_empty", a_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_stretch_pulse.md
# tx_stretch_pulse

Write-domain launcher for the pulse-crossing path. It takes single-cycle event pulses in the wr_clk domain and turns each one into a stretched, registered level pulse that the rd_clk-domain receiver can sample. The receiver fires on the pulse's trailing edge. The block enforces a guaranteed high time and a guaranteed low gap, so the receiver's 2-FF sampler cannot miss or merge events. An optional mode holds the pulse until the receiver acknowledges it. Events arriving while a launch is in flight are dropped and counted.

## Interface
- STRETCH, 4: minimum high cycles of stretched_pulse; legal range ≥1.
- GAP, 2: minimum low cycles after each stretched pulse before the next launch; legal range ≥1.
- USE_ACK, 0: 1 = hold the pulse until rd_ack is seen, then wait for rd_ack to fall.
- CNT_W, 16: width of the sent and drop counters.
- wr_clk  in  1  sole clock.
- wr_resetn  in  1  synchronous, active-low reset, sampled on the wr_clk rising edge.
- wr_pulse  in  1  single-cycle event request; sampled every cycle.
- rd_ack  in  1  asynchronous level from the rd domain; synchronized internally; ignored when USE_ACK=0.
- stretched_pulse  out  1  registered launch level toward the rd domain.
- busy  out  1  high whenever a new wr_pulse would be dropped.
- sent_cnt  out  CNT_W  wrapping count of accepted launches.
- drop_cnt  out  CNT_W  saturating count of rejected wr_pulse cycles.

## Operation
- FSM states and transitions:
  - IDLE → HIGH when wr_pulse=1.
  - HIGH → GAP when the phase counter reaches STRETCH and either USE_ACK=0 or ack_s=1.
  - HIGH → ACK_LOW instead of GAP when USE_ACK=1; the ack_s=1 condition is still required to leave HIGH.
  - ACK_LOW → GAP when ack_s=0.
  - GAP → IDLE after GAP cycles.
- stretched_pulse is 1 only in HIGH. It is driven from the registered state, never combinationally from wr_pulse.
- busy = (state != IDLE).
- A wr_pulse is accepted only in IDLE.
- A wr_pulse in any other state increments drop_cnt. drop_cnt saturates at all-ones. No queuing of dropped pulses.
- sent_cnt increments on every IDLE→HIGH transition and wraps modulo 2^CNT_W.
- Phase counter:
  - Width $clog2(max(STRETCH,GAP)+1).
  - Clears on every state entry; counts cycles spent in HIGH and in GAP.
- ack_s: rd_ack through two flops; reset value 0.
- Reset (any cycle, including mid-HIGH or mid-ACK_LOW): next edge gives state=IDLE, stretched_pulse=0, busy=0, sent_cnt=0, drop_cnt=0, both ack flops 0, phase counter 0.
- Reset dominates a wr_pulse in the same cycle; that pulse is neither sent nor counted.

## Timing
- Launch latency: wr_pulse sampled high at edge t → stretched_pulse=1 and busy=1 after edge t.
- USE_ACK=0:
  - stretched_pulse is high for exactly STRETCH cycles, then low for exactly GAP cycles with busy=1.
  - The next accept is possible at edge t+STRETCH+GAP, giving a peak rate of 1 per STRETCH+GAP cycles.
- USE_ACK=1:
  - High time is max(STRETCH, ack latency). rd_ack reaches ack_s 2 edges after it is sampled.
  - stretched_pulse falls on the edge after ack_s is first 1 with the STRETCH count complete.
  - Low time is ≥ ack-fall latency + GAP.
- A wr_pulse in the last GAP cycle is dropped. A wr_pulse in the first IDLE cycle is accepted.
- The rd domain must run fast enough that STRETCH wr cycles exceed 2 rd cycles. This is an integration requirement, not checked in RTL.

## Structure
- Package tx_pulse_pkg:
  - state typedef: IDLE, HIGH, ACK_LOW, GAP (2-bit encoding).
  - Reset-value localparams.
- Sub-module sync_2ff for rd_ack, reset to 0 by wr_resetn. It is reused by other crossings in the codebase.
- Everything else (FSM, phase counter, both counters) lives in the top module.

## Test plan
- STRETCH=4, GAP=2, USE_ACK=0: wr_pulse at cycle 10 → stretched_pulse 1 in cycles 11–14, 0 from cycle 15; busy 11–16; sent_cnt=1.
- Same config, wr_pulse every cycle 10–19 → accepts at 10 and 17; sent_cnt=2, drop_cnt=8; stretched_pulse high 11–14 and 18–21.
- USE_ACK=1: wr_pulse at 10, rd_ack high at 20, low at 30 → stretched_pulse high 11 through the edge after ack_s=1 (ack_s high at 22, falls at 23); busy until ack_s=0 plus 2 GAP cycles; wr_pulse at 25 dropped.
- wr_resetn low in cycle 12 mid-HIGH (sent_cnt=1) → after the edge: stretched_pulse=0, busy=0, sent_cnt=0, drop_cnt=0; wr_pulse at 14 launches normally.
- CNT_W=4, 20 wr_pulses while busy → drop_cnt holds 15 and does not wrap; 17 accepted launches → sent_cnt=1 (wrap).
- Receiver co-sim at rd_clk = wr_clk/3 with STRETCH=8: 50 random-spaced wr_pulses → receiver event count equals sent_cnt, with no merges.
